// File: rtl/key_input_conditioner.sv
// key_input_conditioner: sync, debounce and press-detect five buttons; deliver one one-hot command per press to the control FSM (ports: clk, reset, key_in[4:0], accept -> enter, moveRight, moveLeft, moveUp, moveDown, pending)
module key_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 19,
  parameter bit KEYS_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] key_in,
  input  logic       accept,
  output logic       enter,
  output logic       moveRight,
  output logic       moveLeft,
  output logic       moveUp,
  output logic       moveDown,
  output logic       pending
);
  typedef enum logic [1:0] {IDLE, HOLD, WAIT_REL} state_t;
  state_t state_q, state_d;
  logic [4:0] kin, sync1_q, sync2_q, stable_q, stable_d, stable_dly_q, press, cmd_q, cmd_d, cmd_out;
  logic [CNT_W-1:0] cnt_q [5];
  logic [CNT_W-1:0] cnt_d [5];
  assign kin = KEYS_ACTIVE_LOW ? ~key_in : key_in;
  assign press = stable_q & ~stable_dly_q;
  assign {enter, moveRight, moveLeft, moveUp, moveDown} = cmd_out;
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < 5; i++) begin
      stable_d[i] = (sync2_q[i] != stable_q[i] && cnt_q[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) ? ~stable_q[i] : stable_q[i];
      cnt_d[i] = (sync2_q[i] == stable_q[i] || cnt_q[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) ? '0 : cnt_q[i] + CNT_W'(1);
    end
  end
  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    cmd_out = '0;
    pending = 1'b0;
    case (state_q)
      IDLE: if (|press) begin
        cmd_d   = press[4] ? 5'b10000 : press[3] ? 5'b01000 : press[2] ? 5'b00100 : press[1] ? 5'b00010 : 5'b00001;
        state_d = HOLD;
      end
      HOLD: begin
        pending = 1'b1;
        cmd_out = accept ? cmd_q : '0;
        state_d = accept ? WAIT_REL : HOLD;
      end
      WAIT_REL: state_d = (stable_q == '0) ? IDLE : WAIT_REL;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      stable_q     <= '0;
      stable_dly_q <= '0;
      cmd_q        <= '0;
      state_q      <= IDLE;
      for (int i = 0; i < 5; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q      <= kin;
      sync2_q      <= sync1_q;
      stable_q     <= stable_d;
      stable_dly_q <= stable_q;
      cmd_q        <= cmd_d;
      state_q      <= state_d;
      for (int i = 0; i < 5; i++) cnt_q[i] <= cnt_d[i];
    end
  end
endmodule
